mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
Round-robin arbiter that sits directly upstream of the 4:1 structural multiplexer. It owns that mux's select lines, address0 and address1. Four requesters compete for the shared mux output path. The arbiter grants one requester at a time, drives the mux address for the granted index, and holds it until the downstream consumer acknowledges. Optionally, it forces release of a grant that is held too long.

Parameters:
HOLD_MAX, 8, maximum consecutive GRANT cycles without ack before forced release (used only with ARB_TIMEOUT_EN); legal range 2..2^CNT_W.
CNT_W, 4, width of the hold counter in bits.

Ports:
clk  input  1  single clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
req  input  4  request lines; req[i] requests mux input in_i.
ack  input  1  downstream consumer accepted the current selection; meaningful only while grant_valid=1.
address0  output  1  mux select LSB (index bit 0), registered.
address1  output  1  mux select MSB (index bit 1), registered.
grant  output  4  one-hot grant, registered; 4'b0000 when no grant.
grant_valid  output  1  high while a grant is active (equals |grant).
timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset, sampled at a rising edge:
  - Outputs: address0=0, address1=0, grant=4'b0000, grant_valid=0, timeout=0.
  - Internal state: state=IDLE, priority pointer ptr=0, hold counter=0.
  - Reset dominates every other input, including mid-grant.
- Index encoding matches the mux: in0 -> (address1,address0)=(0,0); in1 -> (0,1); in2 -> (1,0); in3 -> (1,1).
- Arbitration function: scan req in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first set bit wins.
- State IDLE:
  - If req != 0 at an edge, load grant/address for the winner and go to GRANT.
  - Latency: grant is visible one cycle after req is first sampled high.
- State GRANT, with idx = the current grant index. Events are evaluated at each edge in this priority:
  1. ack=1: release; ptr <= idx+1 mod 4; counter <= 0. Re-arbitrate in the same edge using the new ptr and current req. If any req is set, the next grant appears with no idle bubble and the state stays GRANT; otherwise go to IDLE. The just-served requester wins again only if it is the sole requester.
  2. req[idx]=0 (withdraw, no ack): same release and re-arbitrate as ack. Ack and withdraw together are treated as ack.
  3. Otherwise hold grant and address unchanged; the counter increments (timeout build only).
- Address stability:
  - address0/address1 change only on edges where a new grant is loaded.
  - When grant_valid=0 they hold their last value. The mux output is don't-care then.
- Invariants: grant is always one-hot or zero, and always agrees with address1:address0 when grant_valid=1.
- Changes to req bits other than req[idx] during GRANT have no effect until release.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - A CNT_W-bit hold counter counts GRANT cycles without ack.
  - At an edge where counter==HOLD_MAX-1, ack=0 and req[idx]=1, the arbiter force-releases: ptr <= idx+1, counter <= 0, re-arbitrate exactly as on ack.
  - timeout pulses high for exactly the cycle following that edge.
  - Ack on that same edge wins, so there is no timeout pulse.
- Undefined: no counter is built, timeout is tied 0, and a grant is held indefinitely.

Test Plan:
1. Reset with req=4'b1111 -> next cycle grant=0001, address1:address0=00, grant_valid=1; after ack, grant=0010, address=01 with no bubble.
2. req=4'b1111 held, ack every cycle -> grant sequence 0001,0010,0100,1000,0001; addresses 00,01,10,11,00.
3. Only req[2]=1 from IDLE -> grant=0100, address=10 one cycle later; drop req[2] without ack -> grant=0000, grant_valid=0, address stays 10.
4. Grant on in1, assert reset mid-grant with ack=1 -> next cycle all outputs at reset values; following arbitration starts from ptr=0.
5. ARB_TIMEOUT_EN, HOLD_MAX=4, req=4'b0011, no ack -> grant 0001 for 4 cycles, then timeout=1 for one cycle with grant=0010 and address=01.
6. Same as 5 but ack asserted on the 4th cycle -> grant moves to 0010, timeout stays 0; without the macro, grant 0001 holds for 20+ cycles and timeout stays 0.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the 4:1 mux select lines; grant and address registered, one cycle after request.
// Optional forced release of long-held grants is built when ARB_TIMEOUT_EN is defined.
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       ack,
  output logic       address0,
  output logic       address1,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit CfgOk = (HOLD_MAX >= 2) && (HOLD_MAX <= (1 << CNT_W));

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] idx_q;
  logic [3:0] grant_q;
  logic       timeout_q;

  logic [1:0] nxt_ptr;
  logic [2:0] idle_pick;
  logic [2:0] rel_pick;
  logic       to_ev;
  logic       release_ev;

  // Returns {found, index}: first set bit of r scanning base, base+1, ... mod 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      c = base + 2'(k);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  assign nxt_ptr   = idx_q + 2'd1;
  assign idle_pick = pick(req, ptr_q);
  assign rel_pick  = pick(req, nxt_ptr);

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign to_ev = CfgOk && (state_q == GRANT) && (cnt_q == CNT_W'(HOLD_MAX - 1))
                 && !ack && req[idx_q];

  always_comb begin
    cnt_d = '0;
    if (state_q == GRANT && !release_ev) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  // Without the timeout build a grant is held until ack or withdraw.
  assign to_ev = 1'b0 && CfgOk;
`endif

  assign release_ev = ack || !req[idx_q] || to_ev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      idx_q     <= 2'd0;
      grant_q   <= 4'b0000;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (idle_pick[2]) begin
            idx_q   <= idle_pick[1:0];
            grant_q <= 4'b0001 << idle_pick[1:0];
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (release_ev) begin
            ptr_q     <= nxt_ptr;
            timeout_q <= to_ev;
            // Re-arbitrate on the release edge so back-to-back grants have no bubble.
            if (rel_pick[2]) begin
              idx_q   <= rel_pick[1:0];
              grant_q <= 4'b0001 << rel_pick[1:0];
            end else begin
              grant_q <= 4'b0000;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address0    = idx_q[0];
  assign address1    = idx_q[1];
  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: expected grant/address/timeout queued per step, checked after each edge.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       ack;
  logic       address0;
  logic       address1;
  logic [3:0] grant;
  logic       grant_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] a;
    logic       t;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.HOLD_MAX(4), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .ack         (ack),
    .address0    (address0),
    .address1    (address1),
    .grant       (grant),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r_rst, input logic [3:0] r_req, input logic r_ack,
                      input logic [3:0] eg, input logic [1:0] ea, input logic et,
                      input string tag);
    exp_t e;
    reset = r_rst;
    req   = r_req;
    ack   = r_ack;
    e.g   = eg;
    e.a   = ea;
    e.t   = et;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".grant"}, grant, e.g);
    chk({e.tag, ".addr"}, {2'b00, address1, address0}, {2'b00, e.a});
    chk({e.tag, ".valid"}, {3'b000, grant_valid}, {3'b000, |e.g});
    chk({e.tag, ".timeout"}, {3'b000, timeout}, {3'b000, e.t});
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    ack   = 1'b0;
    @(posedge clk);
    #1;

    // Reset with all requesting, then rotation under continuous ack
    step(1'b1, 4'b1111, 1'b0, 4'b0000, 2'b00, 1'b0, "reset");
    step(1'b0, 4'b1111, 1'b0, 4'b0001, 2'b00, 1'b0, "first_grant");
    step(1'b0, 4'b1111, 1'b1, 4'b0010, 2'b01, 1'b0, "rot1");
    step(1'b0, 4'b1111, 1'b1, 4'b0100, 2'b10, 1'b0, "rot2");
    step(1'b0, 4'b1111, 1'b1, 4'b1000, 2'b11, 1'b0, "rot3");
    step(1'b0, 4'b1111, 1'b1, 4'b0001, 2'b00, 1'b0, "rot_wrap");
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'b00, 1'b0, "ack_to_idle");

    // Single requester, other bits ignored while held, withdraw keeps address
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'b10, 1'b0, "req2_grant");
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'b10, 1'b0, "req2_hold");
    step(1'b0, 4'b1111, 1'b0, 4'b0100, 2'b10, 1'b0, "others_ignored");
    step(1'b0, 4'b0000, 1'b0, 4'b0000, 2'b10, 1'b0, "withdraw_idle");

    // ptr=3 now: scan wraps to in0; sole requester wins again after ack
    step(1'b0, 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b0, "ptr_wrap");
    step(1'b0, 4'b0001, 1'b1, 4'b0001, 2'b00, 1'b0, "sole_rewin");
    step(1'b0, 4'b0010, 1'b0, 4'b0010, 2'b01, 1'b0, "withdraw_regrant");

    // Reset mid-grant with ack; arbitration restarts from ptr=0
    step(1'b1, 4'b1111, 1'b1, 4'b0000, 2'b00, 1'b0, "reset_mid");
    step(1'b0, 4'b1001, 1'b0, 4'b0001, 2'b00, 1'b0, "ptr_after_reset");

`ifdef ARB_TIMEOUT_EN
    // Forced release after HOLD_MAX=4 grant cycles
    step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0, "to_reset");
    step(1'b0, 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b0, "to_c1");
    step(1'b0, 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b0, "to_c2");
    step(1'b0, 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b0, "to_c3");
    step(1'b0, 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b0, "to_c4");
    step(1'b0, 4'b0011, 1'b0, 4'b0010, 2'b01, 1'b1, "to_fire");
    step(1'b0, 4'b0011, 1'b0, 4'b0010, 2'b01, 1'b0, "to_pulse_end");
    // Ack on the timeout edge wins
    step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0, "ak_reset");
    step(1'b0, 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b0, "ak_c1");
    step(1'b0, 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b0, "ak_c2");
    step(1'b0, 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b0, "ak_c3");
    step(1'b0, 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b0, "ak_c4");
    step(1'b0, 4'b0011, 1'b1, 4'b0010, 2'b01, 1'b0, "ak_release");
    step(1'b0, 4'b0011, 1'b0, 4'b0010, 2'b01, 1'b0, "ak_hold");
`else
    // No timeout build: grant held indefinitely
    for (int i = 0; i < 22; i++) begin
      step(1'b0, 4'b1001, 1'b0, 4'b0001, 2'b00, 1'b0, "hold_forever");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
